game2048_nxn_core: RTL
======================

# game2048_nxn_core

Parametrised successor to the fixed 4x4 `game2048` engine: an N×N 2048 game core with one-hot move input, line-serial slide/merge, LFSR-driven tile spawn, score accumulation and win/lose detection. It sits between the button/direction front end and the board renderer/score display. It adds a board preload port so directed verification can start from a known board.

## Interface
- `N`, 4: board dimension, 2..8.
- `TILE_W`, 12: tile value width; tiles hold literal values (0, 2, 4, 8, ...).
- `SCORE_W`, 20: score width.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `num_max_win` in TILE_W: win threshold; any tile ≥ this value wins.
- `direction` in 4: move request, one-hot. Bit 3 = right, bit 2 = left, bit 1 = down, bit 0 = up.
- `load` in 1: preload strobe.
- `load_board` in [N][N]×TILE_W: preload image, row 0 at the top, column 0 at the left.
- `board` out [N][N]×TILE_W: current board, registered.
- `score` out SCORE_W: accumulated merge score.
- `game_state` out 2: 00 PLAY, 01 WIN, 10 LOSE; 11 is never driven.
- `busy` out 1: high whenever the FSM is not in WAIT.
- `moved` out 1: one-cycle pulse when an accepted move changed the board.

## Operation
- FSM states: INIT0, INIT1, WAIT, SLIDE, SPAWN, CHECK, OVER.
- Reset state:
  - state = INIT0.
  - board all zero, score 0, game_state 00.
  - busy 1, moved 0.
  - LFSR = SEED.
- INIT0/INIT1: each spawns one tile, using the SPAWN scan procedure below. INIT1 then goes to CHECK.
- Move acceptance, WAIT only. A move is accepted when `direction` is exactly one-hot and the registered previous `direction` was 0000.
  - Multi-bit or held directions are ignored.
  - Requests made while busy are dropped, not queued.
- SLIDE: processes one line per cycle, N cycles, line index 0..N-1.
  - Rows for left/right; columns for up/down.
  - Standard 2048 rule: compact toward the move side, then merge equal adjacent pairs starting from that side. Each tile merges at most once per move.
  - Example: 2,2,2,2 moved left gives 4,4,0,0.
  - Each merged result is added to `score`.
  - A "changed" flag ORs across all N lines.
- After SLIDE:
  - If changed: pulse `moved` and go to SPAWN.
  - Otherwise go to CHECK with no spawn.
- SPAWN scan:
  - Start index = LFSR[7:0] mod N².
  - Scan one cell per cycle in row-major order with wrap-around. Write a tile into the first empty cell found.
  - At most N² cycles. If no empty cell is found, skip the spawn.
- CHECK, evaluated in this order:
  - Any tile ≥ `num_max_win` → game_state 01, go to OVER.
  - Else, no empty cell and no equal horizontal or vertical neighbours → game_state 10, go to OVER.
  - Else → WAIT.
- OVER: all moves ignored; `load` is still honoured.
- Load:
  - `load`=1 in WAIT or OVER copies `load_board` into `board`, clears game_state to 00 and goes to CHECK.
  - `score` is unchanged.
  - `load` in any other state is ignored.
  - `load` has priority over `direction` in the same cycle.
- Arithmetic:
  - A merge result saturates at 2^(TILE_W-1), the largest representable power of two.
  - `score` saturates at all-ones.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts every cycle, including reset release, so spawn positions depend on move timing.

## Timing
- All outputs are registered.
- Reset release to first WAIT: 2 spawn scans + 1 CHECK cycle, at most 2·N²+1 cycles.
- Accepted move to WAIT:
  - N cycles (SLIDE) + 1 to N² cycles (SPAWN) + 1 cycle (CHECK).
  - N=4: at most 21 cycles.
  - Unchanged board: N+1 cycles.
- `moved` pulses in the first SPAWN cycle.
- `board` line updates are visible one cycle after each SLIDE cycle.
- Reset mid-move aborts immediately to reset values. No partial line is retained.

## Configuration
- `GAME2048_SPAWN4_EN` defined: a spawned tile is 4 when LFSR[10:8]==3'b000, otherwise 2.
- Macro undefined: every spawned tile is 2. This is the default, deterministic for directed tests.

## Structure
- Package `game2048_pkg` holds:
  - The FSM state enum.
  - game_state codes `GS_PLAY`, `GS_WIN`, `GS_LOSE`.
  - Direction bit constants `DIR_RIGHT`, `DIR_LEFT`, `DIR_DOWN`, `DIR_UP`.
  - The LFSR tap mask.
- Sub-module `game2048_line_merge` (combinational):
  - Inputs: N tiles ordered from the move side.
  - Outputs: N compacted/merged tiles, the merge score for the line, and a changed flag.
  - The core orients each row or column into this order and back.

## Test plan
- Reset, then wait 2·N²+1 cycles → exactly two nonzero cells, both equal to 2; score 0; game_state 00; busy 0.
- Load row 0 = 2,2,2,2 with all other cells 0, then pulse left → row 0 = 4,4,x,x with exactly one new 2 somewhere on the board; score 8; `moved` pulses once.
- Load row 0 = 2,4,8,16 with all other cells 0, then pulse left → board unchanged, no spawn, `moved` stays 0, back in WAIT after N+1 cycles.
- Set num_max_win=8, load column 0 = 4,4,0,0, then pulse up → cell (0,0) = 8; game_state 01; a following right pulse is ignored.
- Load a full checkerboard of alternating 2/4 values → after CHECK, game_state 10; `direction` pulses are ignored.
- Hold `direction`=1000 for 30 cycles → exactly one move executes; assert `rst` mid-SLIDE → board 0, score 0, busy 1 within the same cycle.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared types and constants for the N x N 2048 game core: FSM states,
// game_state codes, direction bit positions and the spawn LFSR.
package game2048_pkg;

  typedef enum logic [2:0] {
    ST_INIT0,
    ST_INIT1,
    ST_WAIT,
    ST_SLIDE,
    ST_SPAWN,
    ST_CHECK,
    ST_OVER
  } state_t;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_WIN  = 2'b01;
  localparam logic [1:0] GS_LOSE = 2'b10;

  localparam int DIR_RIGHT = 3;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_UP    = 0;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/game2048_line_merge.sv
// Combinational 2048 line slide: tiles arrive ordered from the move side,
// are compacted, then equal neighbours merge once each from that side.
module game2048_line_merge
  import game2048_pkg::*;
#(
  parameter int N      = 4,
  parameter int TILE_W = 12
) (
  input  logic [N-1:0][TILE_W-1:0] line_in,
  output logic [N-1:0][TILE_W-1:0] line_out,
  output logic [TILE_W+3:0]        line_score,
  output logic                     line_changed
);

  localparam logic [TILE_W-1:0] TILE_MAX = {1'b1, {(TILE_W-1){1'b0}}};

  // Doubling clamps at the largest representable power of two
  function automatic logic [TILE_W-1:0] sat_double(input logic [TILE_W-1:0] v);
    if (v > (TILE_MAX >> 1)) return TILE_MAX;
    return {v[TILE_W-2:0], 1'b0};
  endfunction

  logic [N-1:0][TILE_W-1:0] compact_t;

  always_comb begin
    int k;
    int o;
    logic skip;
    logic [TILE_W-1:0] cur;
    logic [TILE_W-1:0] nxt;
    compact_t  = '0;
    line_out   = '0;
    line_score = '0;
    k    = 0;
    o    = 0;
    skip = 1'b0;
    cur  = '0;
    nxt  = '0;
    for (int i = 0; i < N; i++) begin
      if (line_in[i] != '0) begin
        compact_t[k] = line_in[i];
        k = k + 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      cur = compact_t[i];
      nxt = '0;
      if (i + 1 < N) nxt = compact_t[(i + 1) % N];
      if (skip) begin
        skip = 1'b0;
      end else if (cur != '0) begin
        if (cur == nxt) begin
          line_out[o] = sat_double(cur);
          line_score  = line_score + (TILE_W + 4)'(sat_double(cur));
          skip        = 1'b1;
        end else begin
          line_out[o] = cur;
        end
        o = o + 1;
      end
    end
  end

  assign line_changed = (line_out != line_in);

endmodule

// File: rtl/game2048_nxn_core.sv
// N x N 2048 game engine: line-serial slide/merge, LFSR tile spawn, score and
// win/lose detection. Define GAME2048_SPAWN4_EN to allow spawning 4-tiles.
module game2048_nxn_core
  import game2048_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          TILE_W  = 12,
  parameter int          SCORE_W = 20,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TILE_W-1:0]                num_max_win,
  input  logic [3:0]                       direction,
  input  logic                             load,
  input  logic [N-1:0][N-1:0][TILE_W-1:0] load_board,
  output logic [N-1:0][N-1:0][TILE_W-1:0] board,
  output logic [SCORE_W-1:0]               score,
  output logic [1:0]                       game_state,
  output logic                             busy,
  output logic                             moved
);

  localparam int N2    = N * N;
  localparam int IDX_W = $clog2(N2);
  localparam int LW    = $clog2(N);
  localparam int LS_W  = TILE_W + 4;
  localparam int SUM_W = ((SCORE_W > LS_W) ? SCORE_W : LS_W) + 1;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [LS_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({SCORE_W{1'b1}})) return '1;
    return s[SCORE_W-1:0];
  endfunction

  state_t                   state, state_nxt;
  logic [15:0]              lfsr;
  logic [3:0]               dir_prev, move_dir;
  logic [LW-1:0]            line_idx;
  logic                     chg;
  logic [IDX_W-1:0]         scan_idx, scan_cnt;

  logic [N-1:0][TILE_W-1:0] line_in, line_out;
  logic [LS_W-1:0]          line_score;
  logic                     line_changed;

  logic                     dir_ok, load_ok, spawn_act, spawn_we, spawn_done;
  logic [IDX_W-1:0]         cur_idx, nxt_idx;
  logic [N2-1:0]            empty;
  logic                     any_win, any_empty, any_pair;
  logic [TILE_W-1:0]        spawn_tile;

  game2048_line_merge #(.N(N), .TILE_W(TILE_W)) u_line_merge (
    .line_in     (line_in),
    .line_out    (line_out),
    .line_score  (line_score),
    .line_changed(line_changed)
  );

`ifdef GAME2048_SPAWN4_EN
  assign spawn_tile = (lfsr[10:8] == 3'b000) ? TILE_W'(4) : TILE_W'(2);
`else
  assign spawn_tile = TILE_W'(2);
`endif

  // Orient the selected row/column so index 0 is the side being moved toward
  always_comb begin
    line_in = '0;
    for (int k = 0; k < N; k++) begin
      if (move_dir[DIR_LEFT])       line_in[k] = board[line_idx][k];
      else if (move_dir[DIR_RIGHT]) line_in[k] = board[line_idx][N-1-k];
      else if (move_dir[DIR_UP])    line_in[k] = board[k][line_idx];
      else                          line_in[k] = board[N-1-k][line_idx];
    end
  end

  always_comb begin
    empty     = '0;
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        empty[r*N+c] = (board[r][c] == '0);
        if (board[r][c] == '0) any_empty = 1'b1;
        if (board[r][c] >= num_max_win) any_win = 1'b1;
        if (c < N - 1 && board[r][c] == board[r][(c+1)%N]) any_pair = 1'b1;
        if (r < N - 1 && board[r][c] == board[(r+1)%N][c]) any_pair = 1'b1;
      end
    end
  end

  assign cur_idx    = (scan_cnt == '0) ? IDX_W'(lfsr[7:0] % 8'(N2)) : scan_idx;
  assign nxt_idx    = (cur_idx == IDX_W'(N2 - 1)) ? '0 : cur_idx + 1'b1;
  assign spawn_act  = (state == ST_INIT0) || (state == ST_INIT1) || (state == ST_SPAWN);
  assign spawn_we   = spawn_act && empty[cur_idx];
  assign spawn_done = spawn_we || (spawn_act && scan_cnt == IDX_W'(N2 - 1));
  assign dir_ok     = (direction != 4'b0) && ((direction & (direction - 4'd1)) == 4'b0)
                      && (dir_prev == 4'b0);

  always_comb begin
    state_nxt = state;
    load_ok   = 1'b0;
    case (state)
      ST_INIT0: if (spawn_done) state_nxt = ST_INIT1;
      ST_INIT1: if (spawn_done) state_nxt = ST_CHECK;
      ST_WAIT: begin
        if (load) begin
          load_ok   = 1'b1;
          state_nxt = ST_CHECK;
        end else if (dir_ok) begin
          state_nxt = ST_SLIDE;
        end
      end
      ST_SLIDE: begin
        if (line_idx == LW'(N - 1)) state_nxt = (chg | line_changed) ? ST_SPAWN : ST_CHECK;
      end
      ST_SPAWN: if (spawn_done) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (any_win || (!any_empty && !any_pair)) ? ST_OVER : ST_WAIT;
      ST_OVER: begin
        if (load) begin
          load_ok   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      default: state_nxt = ST_INIT0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT0;
      board      <= '0;
      score      <= '0;
      game_state <= GS_PLAY;
      busy       <= 1'b1;
      moved      <= 1'b0;
      lfsr       <= SEED;
      dir_prev   <= 4'b0;
      move_dir   <= 4'b0;
      line_idx   <= '0;
      chg        <= 1'b0;
      scan_idx   <= '0;
      scan_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_step(lfsr);
      dir_prev <= direction;
      busy     <= (state_nxt != ST_WAIT);
      moved    <= (state == ST_SLIDE) && (state_nxt == ST_SPAWN);

      if (load_ok) begin
        board      <= load_board;
        game_state <= GS_PLAY;
      end else if (state == ST_WAIT && state_nxt == ST_SLIDE) begin
        move_dir <= direction;
        line_idx <= '0;
        chg      <= 1'b0;
      end

      // Write the merged line back through the same orientation it was read with
      if (state == ST_SLIDE) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            if (move_dir[DIR_LEFT] && LW'(r) == line_idx)       board[r][c] <= line_out[c];
            else if (move_dir[DIR_RIGHT] && LW'(r) == line_idx) board[r][c] <= line_out[N-1-c];
            else if (move_dir[DIR_UP] && LW'(c) == line_idx)    board[r][c] <= line_out[r];
            else if (move_dir[DIR_DOWN] && LW'(c) == line_idx)  board[r][c] <= line_out[N-1-r];
          end
        end
        score    <= sat_add(score, line_score);
        chg      <= chg | line_changed;
        line_idx <= (line_idx == LW'(N - 1)) ? '0 : line_idx + 1'b1;
      end

      if (spawn_act) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            if (spawn_we && cur_idx == IDX_W'(r * N + c)) board[r][c] <= spawn_tile;
          end
        end
        if (spawn_done) begin
          scan_cnt <= '0;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
          scan_idx <= nxt_idx;
        end
      end

      if (state == ST_CHECK) begin
        if (any_win)                     game_state <= GS_WIN;
        else if (!any_empty && !any_pair) game_state <= GS_LOSE;
      end
    end
  end

endmodule
